fll_cfg_responder: RTL and testbench



---
 rtl/fll_cfg_responder.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_fll_cfg_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : fll_cfg_responder
//  Description : Responder end of the FLL native configuration bus
//                (req/ack/addr/wdata/rdata/wrn). Holds the four FLL
//                configuration registers (STATUS, CFG1, CFG2, INTEG) and runs
//                the lock-detection state machine fed by periodic DCO-cycle
//                measurements. Synthesizable stand-in for the FLL macro.
//  Options     : `FLL_CFG_RESP_INTEGRATOR_EN - when defined, INTEG is a
//                26-bit read/write register; otherwise it reads as zero and
//                writes are discarded (still acknowledged).
//  Ports       : clk_i         configuration / lock-logic clock
//                rst_ni        synchronous active-low reset
//                req_i         access request (addr/wdata/wrn stable while high)
//                addr_i[1:0]   register index
//                wrn_i         0 = write, 1 = read
//                wdata_i[31:0] write data
//                ack_o         one-cycle access acknowledge
//                rdata_o[31:0] read data, valid while ack_o = 1, else 0
//                meas_valid_i  one-cycle strobe: new measurement available
//                meas_cnt_i    DCO cycles counted in the last reference period
//                lock_o        lock state
//                clk_en_o      output-clock enable toward the gating cell
//                mode_o/div_o/dco_o/mult_o  CFG1 fields
//  Revision    : 1.0 - initial release
// ============================================================================
module fll_cfg_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] MULT_RST   = 16'h05F5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // configuration bus
    input  logic                  req_i,
    input  logic [1:0]            addr_i,
    input  logic                  wrn_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    // measurement input
    input  logic                  meas_valid_i,
    input  logic [15:0]           meas_cnt_i,
    // lock / clock control
    output logic                  lock_o,
    output logic                  clk_en_o,
    // CFG1 fields
    output logic                  mode_o,
    output logic [3:0]            div_o,
    output logic [9:0]            dco_o,
    output logic [15:0]           mult_o
);

    // ------------------------------------------------------------------------
    // Register map
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ADDR_STATUS = 2'd0;
    localparam logic [1:0] c_ADDR_CFG1   = 2'd1;
    localparam logic [1:0] c_ADDR_CFG2   = 2'd2;
    localparam logic [1:0] c_ADDR_INTEG  = 2'd3;

    // CFG2 reset: tol 2, stable 16, unstable 16
    localparam logic [3:0] c_TOL_RST      = 4'd2;
    localparam logic [5:0] c_STABLE_RST   = 6'd16;
    localparam logic [5:0] c_UNSTABLE_RST = 6'd16;

    // ------------------------------------------------------------------------
    // Bus FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_BUS_IDLE    = 2'd0;
    localparam logic [1:0] c_BUS_ACK     = 2'd1;
    localparam logic [1:0] c_BUS_WAITLOW = 2'd2;

    // ------------------------------------------------------------------------
    // Lock FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_LK_UNLOCKED = 2'd0;
    localparam logic [1:0] c_LK_SETTLING = 2'd1;
    localparam logic [1:0] c_LK_LOCKED   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]            r_bus_state;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;

    // CFG1 fields
    logic                  r_mode;
    logic                  r_lock_en;
    logic [3:0]            r_div;
    logic [9:0]            r_dco;
    logic [15:0]           r_mult;

    // CFG2 fields
    logic [3:0]            r_tol;
    logic [5:0]            r_stable;
    logic [5:0]            r_unstable;

    // STATUS measurement capture
    logic [15:0]           r_meas;

    // lock FSM
    logic [1:0]            r_lk_state;
    logic [5:0]            r_stab_cnt;
    logic [5:0]            r_unst_cnt;
    logic                  r_lock;

    // ------------------------------------------------------------------------
    // Access decode: an access happens only on the edge that leaves IDLE, so
    // a held request never produces a second access.
    // ------------------------------------------------------------------------
    logic w_access;
    logic w_wr;
    logic w_wr_cfg1;
    logic w_wr_cfg2;
    logic w_cfg_wr;

    assign w_access  = (r_bus_state == c_BUS_IDLE) && req_i;
    assign w_wr      = w_access && !wrn_i;
    assign w_wr_cfg1 = w_wr && (addr_i == c_ADDR_CFG1);
    assign w_wr_cfg2 = w_wr && (addr_i == c_ADDR_CFG2);
    assign w_cfg_wr  = w_wr_cfg1 || w_wr_cfg2;

    // ------------------------------------------------------------------------
    // Optional integrator register
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_integ_rd;

`ifdef FLL_CFG_RESP_INTEGRATOR_EN
    logic [25:0] r_integ;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_integ <= 26'd0;
        end else if (w_wr && (addr_i == c_ADDR_INTEG)) begin
            r_integ <= wdata_i[25:0];
        end
    end

    assign w_integ_rd = {6'd0, r_integ};
`else
    assign w_integ_rd = '0;
`endif

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (addr_i)
            c_ADDR_STATUS: w_rdata = {15'd0, r_lock, r_meas};
            c_ADDR_CFG1:   w_rdata = {r_mode, r_lock_en, r_div, r_dco, r_mult};
            c_ADDR_CFG2:   w_rdata = {r_tol, r_stable, r_unstable, 16'd0};
            c_ADDR_INTEG:  w_rdata = w_integ_rd;
            default:       w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus FSM: IDLE -> ACK (one cycle) -> WAITLOW (until req drops) -> IDLE.
    // ack/rdata are registered so they appear the cycle after req is sampled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bus_state <= c_BUS_IDLE;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_bus_state)
                c_BUS_IDLE: begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    if (req_i) begin
                        r_bus_state <= c_BUS_ACK;
                        r_ack       <= 1'b1;
                        // write returns 0 on rdata; only reads carry data
                        r_rdata     <= wrn_i ? w_rdata : '0;
                    end
                end
                c_BUS_ACK: begin
                    r_bus_state <= c_BUS_WAITLOW;
                    r_ack       <= 1'b0;
                    r_rdata     <= '0;
                end
                c_BUS_WAITLOW: begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    if (!req_i) begin
                        r_bus_state <= c_BUS_IDLE;
                    end
                end
                default: begin
                    r_bus_state <= c_BUS_IDLE;
                    r_ack       <= 1'b0;
                    r_rdata     <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mode    <= 1'b0;
            r_lock_en <= 1'b1;
            r_div     <= 4'd0;
            r_dco     <= 10'd0;
            r_mult    <= MULT_RST;
        end else if (w_wr_cfg1) begin
            r_mode    <= wdata_i[31];
            r_lock_en <= wdata_i[30];
            r_div     <= wdata_i[29:26];
            r_dco     <= wdata_i[25:16];
            r_mult    <= wdata_i[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tol      <= c_TOL_RST;
            r_stable   <= c_STABLE_RST;
            r_unstable <= c_UNSTABLE_RST;
        end else if (w_wr_cfg2) begin
            r_tol      <= wdata_i[31:28];
            r_stable   <= wdata_i[27:22];
            r_unstable <= wdata_i[21:16];
        end
    end

    // ------------------------------------------------------------------------
    // Tolerance check: 17-bit signed difference so the magnitude never wraps.
    // ------------------------------------------------------------------------
    logic signed [16:0] w_diff;
    logic        [16:0] w_abs_diff;
    logic               w_in_tol;
    logic        [5:0]  w_stab_next;
    logic        [5:0]  w_unst_next;

    assign w_diff      = $signed({1'b0, meas_cnt_i}) - $signed({1'b0, r_mult});
    assign w_abs_diff  = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
    assign w_in_tol    = (w_abs_diff <= {13'd0, r_tol});
    assign w_stab_next = r_stab_cnt + 6'd1;
    assign w_unst_next = r_unst_cnt + 6'd1;

    // ------------------------------------------------------------------------
    // Lock FSM. A configuration write wins over a same-cycle strobe; the
    // strobe's count still lands in STATUS.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_meas     <= 16'd0;
            r_lk_state <= c_LK_UNLOCKED;
            r_stab_cnt <= 6'd0;
            r_unst_cnt <= 6'd0;
            r_lock     <= 1'b0;
        end else begin
            if (meas_valid_i) begin
                r_meas <= meas_cnt_i;
            end

            if (w_cfg_wr) begin
                r_lk_state <= c_LK_UNLOCKED;
                r_stab_cnt <= 6'd0;
                r_unst_cnt <= 6'd0;
                r_lock     <= 1'b0;
            end else if (meas_valid_i) begin
                case (r_lk_state)
                    c_LK_UNLOCKED: begin
                        if (w_in_tol) begin
                            // stable of 0 or 1 is satisfied by this strobe
                            if (r_stable <= 6'd1) begin
                                r_lk_state <= c_LK_LOCKED;
                                r_stab_cnt <= 6'd0;
                                r_lock     <= 1'b1;
                            end else begin
                                r_lk_state <= c_LK_SETTLING;
                                r_stab_cnt <= 6'd1;
                            end
                        end
                    end
                    c_LK_SETTLING: begin
                        if (w_in_tol) begin
                            if (w_stab_next >= r_stable) begin
                                r_lk_state <= c_LK_LOCKED;
                                r_stab_cnt <= 6'd0;
                                r_lock     <= 1'b1;
                            end else begin
                                r_stab_cnt <= w_stab_next;
                            end
                        end else begin
                            r_lk_state <= c_LK_UNLOCKED;
                            r_stab_cnt <= 6'd0;
                        end
                    end
                    c_LK_LOCKED: begin
                        if (w_in_tol) begin
                            r_unst_cnt <= 6'd0;
                        end else if ((r_unstable == 6'd0) ||
                                     (w_unst_next >= r_unstable)) begin
                            r_lk_state <= c_LK_UNLOCKED;
                            r_stab_cnt <= 6'd0;
                            r_unst_cnt <= 6'd0;
                            r_lock     <= 1'b0;
                        end else begin
                            r_unst_cnt <= w_unst_next;
                        end
                    end
                    default: begin
                        r_lk_state <= c_LK_UNLOCKED;
                        r_stab_cnt <= 6'd0;
                        r_unst_cnt <= 6'd0;
                        r_lock     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ack_o    = r_ack;
    assign rdata_o  = r_rdata;
    assign lock_o   = r_lock;
    assign clk_en_o = r_lock_en ? r_lock : 1'b1;
    assign mode_o   = r_mode;
    assign div_o    = r_div;
    assign dco_o    = r_dco;
    assign mult_o   = r_mult;

endmodule
`default_nettype wire

// File: tb/tb_fll_cfg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fll_cfg_responder
//  Description : Directed self-checking bench for fll_cfg_responder: reset
//                state, bus handshake, CFG read/write, lock acquire/loss,
//                write-vs-strobe priority, INTEG register, reset mid-access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fll_cfg_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [1:0]  addr;
    logic        wrn;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        meas_valid;
    logic [15:0] meas_cnt;
    logic        lock;
    logic        clk_en;
    logic        mode;
    logic [3:0]  div;
    logic [9:0]  dco;
    logic [15:0] mult;

    int n_checks   = 0;
    int n_failures = 0;
    int rdata_leak = 0;

    fll_cfg_responder #(
        .DATA_WIDTH (32),
        .MULT_RST   (16'h05F5)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .addr_i       (addr),
        .wrn_i        (wrn),
        .wdata_i      (wdata),
        .ack_o        (ack),
        .rdata_o      (rdata),
        .meas_valid_i (meas_valid),
        .meas_cnt_i   (meas_cnt),
        .lock_o       (lock),
        .clk_en_o     (clk_en),
        .mode_o       (mode),
        .div_o        (div),
        .dco_o        (dco),
        .mult_o       (mult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One bus access with req held for 'hold' sampling edges. Called #1 after
    // a rising edge; returns #1 after a rising edge with the FSM back in IDLE.
    task automatic bus_xfer(input logic [1:0] a, input logic rd, input logic [31:0] wd,
                            input int hold, output logic [31:0] rdv, output int n_ack,
                            output int first_ack, output logic [15:0] mult_at_ack);
        req = 1'b1; addr = a; wrn = rd; wdata = wd;
        n_ack = 0; first_ack = -1; rdv = '0; mult_at_ack = '0;
        for (int i = 0; i < hold + 3; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                n_ack++;
                if (first_ack < 0) begin
                    first_ack   = i;
                    mult_at_ack = mult;
                end
                rdv = rdata;
            end else if (rdata != 32'd0) begin
                rdata_leak++;
            end
            if (i == hold - 1) req = 1'b0;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rdv; int na; int fa; logic [15:0] m;
        bus_xfer(a, 1'b0, d, 1, rdv, na, fa, m);
        check("write_ack_count", 32'(na), 32'd1);
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        int na; int fa; logic [15:0] m;
        bus_xfer(a, 1'b1, 32'd0, 1, d, na, fa, m);
        check("read_ack_count", 32'(na), 32'd1);
    endtask

    task automatic strobe(input logic [15:0] c);
        meas_valid = 1'b1; meas_cnt = c;
        @(posedge clk); #1;
        meas_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] m_at_ack;
        int          na;
        int          fa;
        logic [31:0] integ_exp;

        rst_n = 1'b0; req = 1'b0; addr = 2'd0; wrn = 1'b1; wdata = '0;
        meas_valid = 1'b0; meas_cnt = '0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;

        // ---- reset state ----
        check("rst_ack",    32'(ack),    32'd0);
        check("rst_rdata",  rdata,       32'd0);
        check("rst_lock",   32'(lock),   32'd0);
        check("rst_clk_en", 32'(clk_en), 32'd0);
        check("rst_mult",   32'(mult),   32'h05F5);
        check("rst_fields", {mode, div, dco}, 32'd0);

        do_read(2'd1, rd); check("rd_cfg1_rst",   rd, 32'h4000_05F5);
        do_read(2'd2, rd); check("rd_cfg2_rst",   rd, 32'h2410_0000);
        do_read(2'd0, rd); check("rd_status_rst", rd, 32'h0000_0000);

        // ---- held request: single ack, one cycle after req ----
        bus_xfer(2'd1, 1'b0, 32'h0000_0BEB, 5, rd, na, fa, m_at_ack);
        check("held_ack_count", 32'(na), 32'd1);
        check("held_ack_cycle", 32'(fa), 32'd0);
        check("mult_at_ack",    32'(m_at_ack), 32'h0BEB);
        check("clk_en_lock_en0", 32'(clk_en), 32'd1);
        do_read(2'd1, rd); check("rd_cfg1_back", rd, 32'h0000_0BEB);

        // write non-trivial fields then restore reset value
        do_write(2'd1, 32'hA4D5_05F5);
        check("fields_wr", {mode, div, dco, mult}, {1'b1, 4'h9, 10'h0D5, 16'h05F5});
        do_write(2'd1, 32'h4000_05F5);
        check("clk_en_restored", 32'(clk_en), 32'd0);

        // ---- lock acquisition: 16 in-tolerance strobes ----
        repeat (15) strobe(16'h05F6);
        check("lock_after_15", 32'(lock), 32'd0);
        strobe(16'h05F6);
        check("lock_after_16", 32'(lock),   32'd1);
        check("clk_en_locked", 32'(clk_en), 32'd1);
        do_read(2'd0, rd); check("status_locked", rd, 32'h0001_05F6);

        // ---- lock loss: in-tol strobe clears the miss counter ----
        repeat (15) strobe(16'h0600);
        check("lock_15_miss", 32'(lock), 32'd1);
        strobe(16'h05F5);
        check("lock_after_hit", 32'(lock), 32'd1);
        repeat (15) strobe(16'h0600);
        check("lock_15_more_miss", 32'(lock), 32'd1);
        strobe(16'h0600);
        check("lock_16th_miss", 32'(lock), 32'd0);
        do_read(2'd0, rd); check("status_unlocked", rd, 32'h0000_0600);

        // relock
        repeat (16) strobe(16'h05F6);
        check("relock", 32'(lock), 32'd1);

        // ---- CFG2 write coincident with a strobe ----
        req = 1'b1; addr = 2'd2; wrn = 1'b0; wdata = 32'h2410_0000;
        meas_valid = 1'b1; meas_cnt = 16'h05F7;
        @(posedge clk); #1;
        meas_valid = 1'b0;
        check("coll_ack",  32'(ack),  32'd1);
        check("coll_lock", 32'(lock), 32'd0);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_read(2'd0, rd); check("coll_status", rd, 32'h0000_05F7);
        // a discarded strobe means a full 16 strobes are still needed
        repeat (15) strobe(16'h05F6);
        check("coll_lock_15", 32'(lock), 32'd0);
        strobe(16'h05F6);
        check("coll_lock_16", 32'(lock), 32'd1);

        // ---- INTEG register ----
`ifdef FLL_CFG_RESP_INTEGRATOR_EN
        integ_exp = 32'h03FF_FFFF;
`else
        integ_exp = 32'h0000_0000;
`endif
        do_write(2'd3, 32'hFFFF_FFFF);
        do_read(2'd3, rd); check("integ_rd", rd, integ_exp);

        // STATUS is read-only
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd0, rd); check("status_ro", rd, 32'h0001_05F6);

        // ---- reset during ACK ----
        req = 1'b1; addr = 2'd1; wrn = 1'b0; wdata = 32'h4000_0123;
        @(posedge clk); #1;
        check("pre_rst_ack", 32'(ack), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_drop_ack",  32'(ack),  32'd0);
        check("rst_mult_back", 32'(mult), 32'h05F5);
        check("rst_lock_back", 32'(lock), 32'd0);
        req = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        check("rdata_zero_outside_ack", 32'(rdata_leak), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
